l1_req_traffic_checker: RTL and testbench
=========================================

Name: l1_req_traffic_checker

Overview:
- Self-checking stimulus engine for the L1 data-cache CPU-side req/gnt/rvalid port, parametrised in width, address window and operation count.
- Phase 1 initialises a window of SLOTS words with full-word writes; phase 2 issues NUM_OPS pseudo-random reads and partial writes.
- Every read is checked against an internal shadow memory.
- Sits between bench control and the cache under test; reports pass/fail, error count and a watchdog timeout.

Parameters:
DATA_W, 64, data width in bits; multiple of 32
ADDR_W, 64, address width
SLOTS, 8, words in the checked window; power of two, 2..256
NUM_OPS, 32, random operations after init; 0 allowed
BASE_ADDR, 64'h1000, address of slot 0
STRIDE, 8, byte distance between slots; multiple of DATA_W/8
TIMEOUT, 1024, idle cycles tolerated while waiting for gnt/rvalid

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  begin run; sampled only in IDLE
seed_i  in  32  LFSR seed, latched on start
req_o  out  1  request valid
we_o  out  1  1=write, 0=read
be_o  out  DATA_W/8  byte enables; all zero for reads
addr_o  out  ADDR_W  request address
wdata_o  out  DATA_W  write data; zero for reads
gnt_i  in  1  request accepted
rvalid_i  in  1  read data valid
rdata_i  in  DATA_W  read data
busy_o  out  1  run in progress
done_o  out  1  run finished; held until next start
pass_o  out  1  valid when done_o: err_count_o==0 and no timeout
timeout_o  out  1  watchdog fired
err_count_o  out  16  read mismatches, saturating at 16'hFFFF
op_count_o  out  16  requests granted in the current run

Behaviour:
- Reset (async, rst_ni low): state IDLE. All outputs 0. LFSR=1. Shadow contents undefined. Reset mid-run aborts with no completion flag.
- Single outstanding request. Request fields are registered. They hold stable from req_o rise until the cycle gnt_i==1 with req_o==1.
- Accept: that edge drops req_o and increments op_count_o.
- Writes complete on gnt; no rvalid is expected.
- Reads: after gnt, wait for the first rvalid_i. rvalid_i outside WAIT_RV is ignored.
- gnt_i in the same cycle req_o rises (combinational gnt) is legal and accepted.
- FSM:
  - IDLE: on start_i, latch seed (0 replaced by 1); clear counters, timeout and done; slot k=0 -> INIT_REQ.
  - INIT_REQ: write slot k, be all ones. Data = DATA_W/32 replicas of (32'hC0DE_0000 | k). Shadow[k] updated on gnt. After the last slot -> RAND_REQ, or DONE if NUM_OPS==0.
  - RAND_REQ: advance LFSR one step, then issue from the new value L:
    - we = L[0]
    - slot = L[log2(SLOTS):1]
    - addr = BASE_ADDR + slot*STRIDE, truncated to ADDR_W
    - write be = L[8+DATA_W/8-1:8]; if zero, all ones
    - wdata = DATA_W/32 replicas of L
  - Write gnt: merge enabled bytes into shadow. Read gnt: -> WAIT_RV, remembering the slot.
  - WAIT_RV: on rvalid_i, compare rdata_i with shadow[slot]. On mismatch, err_count_o += 1 (saturating). Then next op, or DONE after NUM_OPS random ops.
  - DONE: done_o=1, busy_o=0, pass_o = (err_count_o==0 && !timeout_o). start_i restarts.
- LFSR: 32-bit Galois, taps 0x80200003, shift right; steps only in RAND_REQ issue.
- Watchdog:
  - Counter clears on any gnt_i or rvalid_i event and on state change.
  - Counts cycles while req_o pending or in WAIT_RV.
  - Reaching TIMEOUT sets timeout_o, drops req_o and goes to DONE with pass_o=0.
- busy_o=1 in every state except IDLE and DONE.

Test Plan:
- Zero-latency memory, SLOTS=2, NUM_OPS=0 -> writes 0xC0DE0000C0DE0000 @0x1000 and 0xC0DE0001C0DE0001 @0x1008; done after 2 grants; op_count_o=2; pass_o=1.
- Cache+memory model, seed=1, NUM_OPS=32 -> pass_o=1, err_count_o=0, op_count_o = 32+SLOTS + 0 extra; requests stable across 3-cycle gnt stalls.
- Faulty memory flipping rdata bit 0 on every read -> err_count_o equals the number of reads issued (predicted from reference LFSR model); pass_o=0.
- gnt_i tied low, TIMEOUT=16 -> timeout_o=1 and done_o=1 exactly 16 cycles after first req_o; req_o=0; pass_o=0.
- seed_i=0 -> same sequence as seed_i=1; start_i pulsed while busy -> ignored.
- rst_ni asserted during WAIT_RV -> all outputs 0 immediately. A subsequent start runs a complete, passing sequence.

Source files
------------

// File: rtl/l1_req_traffic_checker.sv
// Stimulus/check engine for the L1 CPU-side req/gnt/rvalid port: initialises a window of
// slots, then issues LFSR-driven reads and partial writes, checking reads against a shadow copy.
module l1_req_traffic_checker #(
    parameter int          DATA_W    = 64,
    parameter int          ADDR_W    = 64,
    parameter int          SLOTS     = 8,
    parameter int          NUM_OPS   = 32,
    parameter logic [63:0] BASE_ADDR = 64'h1000,
    parameter int          STRIDE    = 8,
    parameter int          TIMEOUT   = 1024
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [31:0]         seed_i,
    output logic                req_o,
    output logic                we_o,
    output logic [DATA_W/8-1:0] be_o,
    output logic [ADDR_W-1:0]   addr_o,
    output logic [DATA_W-1:0]   wdata_o,
    input  logic                gnt_i,
    input  logic                rvalid_i,
    input  logic [DATA_W-1:0]   rdata_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                pass_o,
    output logic                timeout_o,
    output logic [15:0]         err_count_o,
    output logic [15:0]         op_count_o
);
    localparam int BW   = DATA_W / 8;
    localparam int SW   = $clog2(SLOTS);
    localparam int NREP = DATA_W / 32;

    typedef enum logic [2:0] {S_IDLE, S_INIT_REQ, S_RAND_REQ, S_WAIT_RV, S_DONE} state_e;

    state_e              state_q, state_d;
    logic                req_q, req_d, we_q, we_d;
    logic [BW-1:0]       be_q, be_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]       slot_q, slot_d;
    logic [31:0]         lfsr_q, lfsr_d, rcnt_q, rcnt_d, wd_q, wd_d;
    logic                done_q, done_d, tmo_q, tmo_d;
    logic [15:0]         err_q, err_d, opc_q, opc_d;
    logic [DATA_W-1:0]   shadow_q [SLOTS];
    logic                sh_we;
    logic [DATA_W-1:0]   sh_wdata;
    logic [31:0]         lfsr_nxt;
    logic [BW-1:0]       be_rand;
    logic                rand_last, counting;

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
    endfunction

    function automatic logic [ADDR_W-1:0] slot_addr(input logic [SW-1:0] s);
        logic [63:0] a;
        a = BASE_ADDR + 64'(s) * 64'(STRIDE);
        return ADDR_W'(a);
    endfunction

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        be_d     = be_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        slot_d   = slot_q;
        lfsr_d   = lfsr_q;
        rcnt_d   = rcnt_q;
        wd_d     = wd_q;
        done_d   = done_q;
        tmo_d    = tmo_q;
        err_d    = err_q;
        opc_d    = opc_q;
        sh_we    = 1'b0;
        sh_wdata = '0;
        for (int b = 0; b < BW; b++) begin
            sh_wdata[b*8 +: 8] = be_q[b] ? wdata_q[b*8 +: 8] : shadow_q[slot_q][b*8 +: 8];
        end
        lfsr_nxt  = lfsr_step(lfsr_q);
        be_rand   = BW'(lfsr_nxt >> 8);
        rand_last = (rcnt_q + 32'd1) == 32'(NUM_OPS);
        counting  = req_q || (state_q == S_WAIT_RV);

        // After each grant req drops for one cycle; the next request is raised from the idle cycle.
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d = S_INIT_REQ;
                    lfsr_d  = (seed_i == 32'd0) ? 32'd1 : seed_i;
                    opc_d   = '0;
                    err_d   = '0;
                    tmo_d   = 1'b0;
                    done_d  = 1'b0;
                    rcnt_d  = '0;
                    slot_d  = '0;
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    be_d    = '1;
                    addr_d  = slot_addr('0);
                    wdata_d = {NREP{32'hC0DE_0000}};
                end
            end
            S_INIT_REQ: begin
                if (!req_q) begin
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    be_d    = '1;
                    addr_d  = slot_addr(slot_q);
                    wdata_d = {NREP{32'hC0DE_0000 | 32'(slot_q)}};
                end else if (gnt_i) begin
                    req_d = 1'b0;
                    opc_d = opc_q + 16'd1;
                    sh_we = 1'b1;
                    if (slot_q == SW'(SLOTS - 1)) begin
                        state_d = (NUM_OPS == 0) ? S_DONE : S_RAND_REQ;
                    end else begin
                        slot_d = slot_q + 1'b1;
                    end
                end
            end
            S_RAND_REQ: begin
                if (!req_q) begin
                    lfsr_d = lfsr_nxt;
                    req_d  = 1'b1;
                    we_d   = lfsr_nxt[0];
                    slot_d = SW'(lfsr_nxt >> 1);
                    addr_d = slot_addr(SW'(lfsr_nxt >> 1));
                    if (lfsr_nxt[0]) begin
                        be_d    = (be_rand == '0) ? '1 : be_rand;
                        wdata_d = {NREP{lfsr_nxt}};
                    end else begin
                        be_d    = '0;
                        wdata_d = '0;
                    end
                end else if (gnt_i) begin
                    req_d = 1'b0;
                    opc_d = opc_q + 16'd1;
                    if (we_q) begin
                        sh_we   = 1'b1;
                        rcnt_d  = rcnt_q + 32'd1;
                        state_d = rand_last ? S_DONE : S_RAND_REQ;
                    end else begin
                        state_d = S_WAIT_RV;
                    end
                end
            end
            S_WAIT_RV: begin
                if (rvalid_i) begin
                    if ((rdata_i != shadow_q[slot_q]) && (err_q != 16'hFFFF)) begin
                        err_d = err_q + 16'd1;
                    end
                    rcnt_d  = rcnt_q + 32'd1;
                    state_d = rand_last ? S_DONE : S_RAND_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if ((state_d == S_DONE) && (state_q != S_DONE)) begin
            done_d = 1'b1;
        end

        // Watchdog: only runs while stuck waiting on the memory side.
        if ((state_d != state_q) || gnt_i || rvalid_i || !counting) begin
            wd_d = '0;
        end else if (wd_q == 32'(TIMEOUT - 1)) begin
            tmo_d   = 1'b1;
            req_d   = 1'b0;
            state_d = S_DONE;
            done_d  = 1'b1;
            wd_d    = '0;
        end else begin
            wd_d = wd_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            slot_q  <= '0;
            lfsr_q  <= 32'd1;
            rcnt_q  <= '0;
            wd_q    <= '0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
            err_q   <= '0;
            opc_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            slot_q  <= slot_d;
            lfsr_q  <= lfsr_d;
            rcnt_q  <= rcnt_d;
            wd_q    <= wd_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            opc_q   <= opc_d;
        end
    end

    // Shadow contents need no reset: every run rewrites all slots before reading any.
    always_ff @(posedge clk_i) begin
        if (sh_we) begin
            shadow_q[slot_q] <= sh_wdata;
        end
    end

    assign req_o       = req_q;
    assign we_o        = we_q;
    assign be_o        = be_q;
    assign addr_o      = addr_q;
    assign wdata_o     = wdata_q;
    assign busy_o      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o      = done_q;
    assign pass_o      = done_q && (err_q == 16'd0) && !tmo_q;
    assign timeout_o   = tmo_q;
    assign err_count_o = err_q;
    assign op_count_o  = opc_q;
endmodule

// File: tb/tb_l1_req_traffic_checker.sv
// Bench for l1_req_traffic_checker: behavioural memory responder plus a reference request model.
module tb_l1_req_traffic_checker;
    localparam int SL   = 8;
    localparam int NOPS = 32;

    typedef struct packed {
        logic        we;
        logic [7:0]  be;
        logic [63:0] addr;
        logic [63:0] wdata;
    } req_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_ni, start, start2;
    logic [31:0] seed;
    logic        req, we, gnt, busy, done, pass, tmo_o;
    logic [7:0]  be;
    logic [63:0] addr, wdata;
    logic        rvalid = 1'b0;
    logic [63:0] rdata  = '0;
    logic [15:0] err, opc;

    logic        req2, we2, gnt2, rv2, busy2, done2, pass2, tmo2;
    logic [7:0]  be2;
    logic [63:0] addr2, wdata2, rd2;
    logic [15:0] err2, opc2;

    assign gnt2 = req2;
    assign rv2  = 1'b0;
    assign rd2  = '0;

    l1_req_traffic_checker #(.DATA_W(64), .ADDR_W(64), .SLOTS(SL), .NUM_OPS(NOPS),
        .BASE_ADDR(64'h1000), .STRIDE(8), .TIMEOUT(16)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start), .seed_i(seed),
        .req_o(req), .we_o(we), .be_o(be), .addr_o(addr), .wdata_o(wdata),
        .gnt_i(gnt), .rvalid_i(rvalid), .rdata_i(rdata),
        .busy_o(busy), .done_o(done), .pass_o(pass), .timeout_o(tmo_o),
        .err_count_o(err), .op_count_o(opc));

    l1_req_traffic_checker #(.DATA_W(64), .ADDR_W(64), .SLOTS(2), .NUM_OPS(0),
        .BASE_ADDR(64'h1000), .STRIDE(8), .TIMEOUT(1024)) dut2 (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start2), .seed_i(seed),
        .req_o(req2), .we_o(we2), .be_o(be2), .addr_o(addr2), .wdata_o(wdata2),
        .gnt_i(gnt2), .rvalid_i(rv2), .rdata_i(rd2),
        .busy_o(busy2), .done_o(done2), .pass_o(pass2), .timeout_o(tmo2),
        .err_count_o(err2), .op_count_o(opc2));

    int n_chk = 0, n_pass = 0;

    // Memory responder configuration (written by tests while the DUT is idle).
    int stall_cyc = 0, rd_lat = 0;
    bit flip_rd = 0, gnt_block = 0;

    // Responder state (written only by the responder process).
    bit          gnt_en = 0, rv_pend = 0, hold_v = 0;
    int          stall_cnt = 0, rv_cnt = 0, stab_err = 0;
    logic [63:0] rv_data;
    logic [63:0] mem [logic [63:0]];
    req_t        obs[$], obs2[$], held, cur;
    req_t        exp_q[$];

    assign gnt = req && gnt_en;

    always @(negedge clk) begin
        if (!rst_ni) begin
            rvalid = 1'b0; rv_pend = 0; hold_v = 0; stall_cnt = 0; gnt_en = 0;
        end else begin
            rvalid = 1'b0;
            if (rv_pend) begin
                if (rv_cnt == 0) begin rvalid = 1'b1; rdata = rv_data; rv_pend = 0; end
                else rv_cnt--;
            end
            if (req) begin
                cur = '{we, be, addr, wdata};
                if (hold_v && cur != held) stab_err++;
                if (!hold_v) begin held = cur; hold_v = 1; end
                if (gnt_block) gnt_en = 0;
                else if (stall_cnt < stall_cyc) begin gnt_en = 0; stall_cnt++; end
                else gnt_en = 1;
                if (gnt_en) begin
                    logic [63:0] w;
                    obs.push_back(cur);
                    hold_v = 0; stall_cnt = 0;
                    w = mem.exists(addr) ? mem[addr] : 64'd0;
                    if (we) begin
                        for (int b = 0; b < 8; b++) if (be[b]) w[b*8 +: 8] = wdata[b*8 +: 8];
                        mem[addr] = w;
                    end else begin
                        rv_pend = 1; rv_cnt = rd_lat;
                        rv_data = flip_rd ? (w ^ 64'd1) : w;
                    end
                end
            end else begin
                hold_v = 0; stall_cnt = 0;
                gnt_en = !gnt_block && (stall_cyc == 0);
            end
        end
    end

    always @(negedge clk) if (rst_ni && req2) obs2.push_back('{we2, be2, addr2, wdata2});

    // Reference: the request stream a run must produce, from the seed alone.
    function automatic void build_model(input logic [31:0] s, input int slots, input int nops,
                                        output int nreads);
        logic [31:0] l;
        int          slot;
        req_t        r;
        exp_q.delete();
        nreads = 0;
        for (int k = 0; k < slots; k++) begin
            r.we = 1'b1; r.be = 8'hFF; r.addr = 64'h1000 + 64'(8 * k);
            r.wdata = {2{32'hC0DE0000 + 32'(k)}};
            exp_q.push_back(r);
        end
        l = (s == 32'd0) ? 32'd1 : s;
        for (int i = 0; i < nops; i++) begin
            l = l[0] ? ((l >> 1) ^ 32'h80200003) : (l >> 1);
            slot = int'((l >> 1) % 32'(slots));
            r.addr = 64'h1000 + 64'(slot * 8);
            if (l[0]) begin
                r.we = 1'b1; r.be = (l[15:8] == 8'd0) ? 8'hFF : l[15:8]; r.wdata = {l, l};
            end else begin
                r.we = 1'b0; r.be = 8'd0; r.wdata = 64'd0; nreads++;
            end
            exp_q.push_back(r);
        end
    endfunction

    task automatic pulse_start(input logic [31:0] s);
        @(negedge clk); seed = s; start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 0;
        for (int c = 0; c < 5000; c++) begin
            if (done) begin ok = 1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_ni = 1'b0; start = 1'b0; start2 = 1'b0; seed = '0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({req, we, be, addr, wdata, busy, done, pass, tmo_o, err, opc} !== '0)
            $display("FAIL reset_outputs got req=%b busy=%b done=%b addr=%h opc=%0d want all 0",
                     req, busy, done, addr, opc);
        else n_pass++;
        n_chk++;
        if ({req2, we2, be2, addr2, wdata2, busy2, done2, pass2, tmo2, err2, opc2} !== '0)
            $display("FAIL reset_outputs2 got req=%b busy=%b done=%b want all 0", req2, busy2, done2);
        else n_pass++;
        @(negedge clk); rst_ni = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_init_only;
        int   base2;
        bit   ok;
        req_t e0, e1;
        e0 = '{1'b1, 8'hFF, 64'h1000, 64'hC0DE0000C0DE0000};
        e1 = '{1'b1, 8'hFF, 64'h1008, 64'hC0DE0001C0DE0001};
        base2 = obs2.size();
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        ok = 0;
        for (int c = 0; c < 100; c++) begin
            if (done2) begin ok = 1; break; end
            @(negedge clk);
        end
        n_chk++; if (!ok) $display("FAIL init_done got done=%b want 1", done2); else n_pass++;
        n_chk++;
        if (obs2.size() - base2 != 2) $display("FAIL init_grants got %0d want 2", obs2.size() - base2);
        else n_pass++;
        n_chk++;
        if (obs2.size() < base2 + 2 || obs2[base2] !== e0)
            $display("FAIL init_write0 got %h want %h", (obs2.size() > base2) ? obs2[base2] : '0, e0);
        else n_pass++;
        n_chk++;
        if (obs2.size() < base2 + 2 || obs2[base2+1] !== e1)
            $display("FAIL init_write1 got %h want %h", (obs2.size() > base2 + 1) ? obs2[base2+1] : '0, e1);
        else n_pass++;
        n_chk++; if (opc2 !== 16'd2) $display("FAIL init_opcount got %0d want 2", opc2); else n_pass++;
        n_chk++;
        if ({pass2, busy2, tmo2, err2} !== {1'b1, 1'b0, 1'b0, 16'd0})
            $display("FAIL init_status got pass=%b busy=%b tmo=%b err=%0d want 1 0 0 0", pass2, busy2, tmo2, err2);
        else n_pass++;
    endtask

    task automatic check_stream(input string name, input int base);
        n_chk++;
        if (obs.size() - base != exp_q.size())
            $display("FAIL %s_len got %0d want %0d", name, obs.size() - base, exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < obs.size()) begin
                n_chk++;
                if (obs[base+i] !== exp_q[i])
                    $display("FAIL %s_req%0d got %h want %h", name, i, obs[base+i], exp_q[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_random_traffic(input logic [31:0] s, input int st, input int lat);
        int base, sb, nr;
        bit ok;
        stall_cyc = st; rd_lat = lat; flip_rd = 0;
        build_model(s, SL, NOPS, nr);
        sb = stab_err; base = obs.size();
        pulse_start(s);
        wait_done(ok);
        n_chk++; if (!ok) $display("FAIL traffic_done got done=%b want 1", done); else n_pass++;
        check_stream("traffic", base);
        n_chk++; if (stab_err != sb) $display("FAIL traffic_stable got %0d changes want 0", stab_err - sb); else n_pass++;
        n_chk++; if (opc !== 16'(NOPS + SL)) $display("FAIL traffic_opcount got %0d want %0d", opc, NOPS + SL); else n_pass++;
        n_chk++;
        if ({pass, err, tmo_o, busy} !== {1'b1, 16'd0, 1'b0, 1'b0})
            $display("FAIL traffic_status got pass=%b err=%0d tmo=%b busy=%b want 1 0 0 0", pass, err, tmo_o, busy);
        else n_pass++;
    endtask

    task automatic test_faulty_reads;
        int          base, nr;
        bit          ok;
        logic [31:0] s;
        s = $urandom;
        stall_cyc = $urandom_range(0, 3); rd_lat = $urandom_range(0, 3); flip_rd = 1;
        build_model(s, SL, NOPS, nr);
        base = obs.size();
        pulse_start(s);
        wait_done(ok);
        flip_rd = 0;
        n_chk++; if (!ok) $display("FAIL faulty_done got done=%b want 1", done); else n_pass++;
        n_chk++; if (err !== 16'(nr)) $display("FAIL faulty_errcount got %0d want %0d", err, nr); else n_pass++;
        n_chk++; if (pass !== (nr == 0)) $display("FAIL faulty_pass got %b want %b", pass, nr == 0); else n_pass++;
        n_chk++; if (opc !== 16'(NOPS + SL)) $display("FAIL faulty_opcount got %0d want %0d", opc, NOPS + SL); else n_pass++;
    endtask

    task automatic test_seed_zero_and_restart;
        int base, nr;
        bit ok;
        stall_cyc = 1; rd_lat = 1;
        build_model(32'd1, SL, NOPS, nr);
        base = obs.size();
        pulse_start(32'd0);
        repeat (15) @(negedge clk);
        n_chk++; if (busy !== 1'b1) $display("FAIL seed0_busy got %b want 1", busy); else n_pass++;
        seed = 32'hDEAD_BEEF; start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_done(ok);
        n_chk++; if (!ok) $display("FAIL seed0_done got done=%b want 1", done); else n_pass++;
        check_stream("seed0", base);
        n_chk++; if (opc !== 16'(NOPS + SL)) $display("FAIL seed0_opcount got %0d want %0d", opc, NOPS + SL); else n_pass++;
        n_chk++; if (pass !== 1'b1) $display("FAIL seed0_pass got %b want 1", pass); else n_pass++;
    endtask

    task automatic test_timeout;
        int n;
        gnt_block = 1; stall_cyc = 0;
        pulse_start(32'd7);
        for (int k = 0; k < 10 && !req; k++) @(negedge clk);
        n_chk++; if (req !== 1'b1) $display("FAIL tmo_req_rise got %b want 1", req); else n_pass++;
        n = 0;
        while (!done && n < 100) begin @(negedge clk); n++; end
        gnt_block = 0;
        n_chk++; if (n != 16) $display("FAIL tmo_latency got %0d cycles want 16", n); else n_pass++;
        n_chk++;
        if ({tmo_o, done, req, pass, busy} !== 5'b11000)
            $display("FAIL tmo_status got tmo=%b done=%b req=%b pass=%b busy=%b want 1 1 0 0 0",
                     tmo_o, done, req, pass, busy);
        else n_pass++;
        n_chk++; if (opc !== 16'd0) $display("FAIL tmo_opcount got %0d want 0", opc); else n_pass++;
    endtask

    task automatic test_reset_mid_run;
        int          nr, tries, base;
        bit          found, ok;
        logic [31:0] s;
        stall_cyc = 0; rd_lat = 5;
        tries = 0;
        do begin s = $urandom; build_model(s, SL, NOPS, nr); tries++; end while (nr == 0 && tries < 10);
        pulse_start(s);
        found = 0;
        for (int c = 0; c < 2000; c++) begin
            if (rv_pend && !req && busy) begin found = 1; break; end
            @(negedge clk);
        end
        n_chk++; if (!found) $display("FAIL rst_waitrv got no read in flight want one"); else n_pass++;
        #2 rst_ni = 1'b0;
        #1;
        n_chk++;
        if ({req, we, be, addr, wdata, busy, done, pass, tmo_o, err, opc} !== '0)
            $display("FAIL rst_midrun got req=%b busy=%b done=%b opc=%0d want all 0", req, busy, done, opc);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk);
        rd_lat = 2;
        base = obs.size();
        pulse_start(s);
        wait_done(ok);
        n_chk++; if (!ok) $display("FAIL rst_rerun_done got done=%b want 1", done); else n_pass++;
        check_stream("rst_rerun", base);
        n_chk++;
        if ({pass, err, opc} !== {1'b1, 16'd0, 16'(NOPS + SL)})
            $display("FAIL rst_rerun_status got pass=%b err=%0d opc=%0d want 1 0 %0d", pass, err, opc, NOPS + SL);
        else n_pass++;
    endtask

    initial begin
        #3000000;
        $display("FAIL global_timeout got no summary want completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_init_only();
        test_random_traffic(32'd1, 3, 2);
        test_random_traffic($urandom, $urandom_range(0, 3), $urandom_range(0, 4));
        test_faulty_reads();
        test_seed_zero_and_restart();
        test_timeout();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
